shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multicycle shift unit controller that executes ARM data-processing shifts (LSL, LSR, ASR, ROR, RRX) by any amount 0–255 with architecturally correct carry-out. It sits beside the single-cycle shifter, and the main control FSM hands it register-specified shifts. Each shift is processed as a sequence of bounded sub-shifts, at most STEP bits per cycle, so no full 32-bit barrel is needed on the critical path. The block uses a start/busy/done handshake toward the main controller.

## Interface
- STEP, default 4: maximum bits shifted per RUN cycle; must be a power of two, 1..32.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- rrx  in  1  when set with op=11, performs RRX; amount is ignored.
- amount  in  8  shift amount (Rs[7:0] or imm5 zero-extended).
- operand  in  32  Rm value.
- carry_in  in  1  current CPSR C flag.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result and carry_out are valid.
- result  out  32  shifted value; held until the next accepted start.
- carry_out  out  1  shifter carry; held with result.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE to RUN on start when eff > 0.
  - IDLE to DONE on start when eff = 0.
  - RUN to DONE when remaining reaches 0 after the current step.
  - DONE to IDLE unconditionally.
- On an accepted start, the block captures operand into result and carry_in into carry_out, then loads remaining = eff.
- Effective count (eff):
  - LSL/LSR: min(amount, 33).
  - ASR: min(amount, 32).
  - ROR: 0 if amount = 0; 32 if amount[4:0] = 0; otherwise amount[4:0].
  - RRX: 1.
- Each RUN cycle shifts by k = min(remaining, STEP) and decrements remaining by k.
- After each step, carry_out = the last bit shifted out (the bit at position k−1 for right shifts, 32−k for LSL, of the pre-step value).
- Fill rules:
  - LSL/LSR fill with 0.
  - ASR fills with result[31].
  - ROR rotates.
  - RRX: result = {carry_in, operand[31:1]}, carry_out = operand[0].
- These rules yield the ARM cases with no special casing:
  - LSL/LSR 32 gives carry = the boundary bit.
  - Amounts above 32 give result 0, carry 0.
  - ASR ≥ 32 gives all sign bits, carry = sign.
  - ROR by a nonzero multiple of 32 leaves the value unchanged, carry = bit 31.
  - Amount 0 leaves the value unchanged, carry = carry_in.
- While busy, start and all inputs are ignored. Inputs are latched only at acceptance.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, carry_out 0, remaining 0.
- Reset in any state, including mid-RUN, aborts the operation. No done is issued.
- Latency from the start-sampling edge to done high is ceil(eff/STEP) + 1 cycles.
  - eff = 0 gives done in the next cycle.
  - With STEP=4, LSL 33 takes 10 cycles.
- done is high for exactly one cycle. busy falls with the DONE to IDLE transition.
- start is accepted in the first IDLE cycle after DONE, so back-to-back operations lose one cycle.
- result and carry_out change only in RUN cycles and at acceptance. They are stable from done until the next accepted start.

## Structure
- Package shift_pkg holds:
  - shift_op_e (LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11), shared with the decoder and the single-cycle shifter.
  - seq_state_e (IDLE, RUN, DONE).
  - Constant WORD_W = 32.
  - Constants LSL_MAX_EFF = 33, ASR_MAX_EFF = 32.
- One combinational sub-module, shift_step, handles a single step:
  - Inputs: value, op, rrx, k (0..STEP), carry_in.
  - Outputs: next value, carry.
- shift_sequencer holds the FSM, the eff computation and the remaining counter.

## Test plan
All scenarios use STEP=4 unless stated.
1. LSL, amount 4, operand 0x8000_000F, carry_in 0 → result 0x0000_00F0, carry_out 0, done 2 cycles after start.
2. LSR, amount 32, operand 0x8000_0001 → result 0, carry 1, done at cycle 9. LSR, amount 40, same operand → result 0, carry 0, done at cycle 10.
3. ASR, amount 200, operand 0x8000_0000 → result 0xFFFF_FFFF, carry 1, done at cycle 9.
4. ROR, amount 36, operand 0x0000_0013 → result 0x3000_0001, carry 0. ROR, amount 32, operand 0x8000_0000 → result 0x8000_0000, carry 1.
5. RRX, operand 0x0000_0003, carry_in 1 → result 0x8000_0001, carry 1, done at cycle 2. LSL, amount 0, carry_in 1 → result unchanged, carry 1, done at cycle 1.
6. Start pulsed while busy is ignored: the first result is unaffected. Reset asserted mid-RUN → all outputs 0 next cycle, no done pulse. Repeat scenario 1 with STEP=1 → done at cycle 5, same result.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shift-type encodings, sequencer states and the effective-count rule
// used by the multicycle shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    localparam int WORD_W      = 32;
    localparam int LSL_MAX_EFF = 33;
    localparam int ASR_MAX_EFF = 32;

    // Saturating the count at 33/32 lets plain bit-by-bit shifting reproduce
    // every ARM out-of-range case without special handling in the datapath.
    function automatic logic [5:0] eff_count(input shift_op_e op, input logic rrx,
                                             input logic [7:0] amount);
        logic [5:0] e;
        e = '0;
        case (op)
            LSL, LSR: e = (amount > 8'(LSL_MAX_EFF)) ? 6'(LSL_MAX_EFF) : amount[5:0];
            ASR:      e = (amount > 8'(ASR_MAX_EFF)) ? 6'(ASR_MAX_EFF) : amount[5:0];
            ROR: begin
                if (rrx)                    e = 6'd1;
                else if (amount == 8'd0)    e = 6'd0;
                else if (amount[4:0] == '0) e = 6'd32;
                else                        e = {1'b0, amount[4:0]};
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One bounded sub-shift of 0..32 bits, producing the shifted word and the
// last bit shifted out (carry_in passes through when k is zero).
module shift_step
    import shift_pkg::*;
(
    input  logic [WORD_W-1:0] value,
    input  shift_op_e         op,
    input  logic              rrx,
    input  logic [5:0]        k,
    input  logic              carry_in,
    output logic [WORD_W-1:0] next_value,
    output logic              carry
);

    logic [4:0] lo_idx;
    logic [4:0] hi_idx;

    // Bit k-1 leaves last on right shifts, bit 32-k on a left shift.
    assign lo_idx = 5'(k - 6'd1);
    assign hi_idx = 5'(6'd32 - k);

    always_comb begin
        next_value = value;
        carry      = carry_in;
        if (k != 6'd0) begin
            case (op)
                LSL: begin
                    next_value = value << k;
                    carry      = value[hi_idx];
                end
                LSR: begin
                    next_value = value >> k;
                    carry      = value[lo_idx];
                end
                ASR: begin
                    next_value = $signed(value) >>> k;
                    carry      = value[lo_idx];
                end
                ROR: begin
                    if (rrx) begin
                        next_value = {carry_in, value[WORD_W-1:1]};
                        carry      = value[0];
                    end else begin
                        next_value = (value >> k) | (value << (6'd32 - k));
                        carry      = value[lo_idx];
                    end
                end
                default: begin
                    next_value = value;
                    carry      = carry_in;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle ARM shift controller: breaks a register-specified shift into
// sub-shifts of at most STEP bits and reports completion with a done pulse.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              rrx,
    input  logic [7:0]        amount,
    input  logic [WORD_W-1:0] operand,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              carry_out,
    output seq_state_e        dbg_state
);

    // Handshake: start is sampled only in IDLE; an accepted start latches all
    // inputs and raises busy. busy stays high through RUN and DONE, done is a
    // single-cycle pulse in DONE, and result/carry_out hold until the next
    // accepted start. Inputs, including start, are ignored while busy.

    localparam logic [5:0] STEP_K = 6'(STEP);

    seq_state_e        state_q, state_d;
    logic [5:0]        remaining;
    logic [5:0]        eff;
    logic [5:0]        k;
    shift_op_e         op_q;
    logic              rrx_q;
    logic [WORD_W-1:0] step_value;
    logic              step_carry;

    assign eff = eff_count(shift_op_e'(op), rrx, amount);
    assign k   = (remaining < STEP_K) ? remaining : STEP_K;

    shift_step u_step (
        .value      (result),
        .op         (op_q),
        .rrx        (rrx_q),
        .k          (k),
        .carry_in   (carry_out),
        .next_value (step_value),
        .carry      (step_carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (eff == 6'd0) ? DONE : RUN;
            RUN:     if (remaining <= STEP_K) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            remaining <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            op_q      <= LSL;
            rrx_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                result    <= operand;
                carry_out <= carry_in;
                remaining <= eff;
                op_q      <= shift_op_e'(op);
                rrx_q     <= rrx && (op == 2'b11);
            end else if (state_q == RUN) begin
                result    <= step_value;
                carry_out <= step_carry;
                remaining <= remaining - k;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: STEP=4 and STEP=1 instances run the same
// operations and are compared against an architectural ARM shift model.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        rrx;
    logic [7:0]  amount;
    logic [31:0] operand;
    logic        carry_in;

    logic        busy4, done4, co4;
    logic [31:0] res4;
    seq_state_e  st4;
    logic        busy1, done1, co1;
    logic [31:0] res1;
    seq_state_e  st1;

    int vectors     = 0;
    int miscompares = 0;

    // clock / reset
    always #5 clk = ~clk;

    shift_sequencer #(.STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .rrx(rrx),
        .amount(amount), .operand(operand), .carry_in(carry_in),
        .busy(busy4), .done(done4), .result(res4), .carry_out(co4),
        .dbg_state(st4)
    );

    shift_sequencer #(.STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .rrx(rrx),
        .amount(amount), .operand(operand), .carry_in(carry_in),
        .busy(busy1), .done(done1), .result(res1), .carry_out(co1),
        .dbg_state(st1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural ARM shifter result plus the sequencer's effective count.
    function automatic void model(input logic [1:0] o, input logic r, input logic [7:0] a,
                                  input logic [31:0] x, input logic ci,
                                  output logic [31:0] res, output logic co, output int eff);
        int n;
        int m;
        logic [63:0] dbl;
        n = a;
        if (o == 2'b11 && r) begin
            res = {ci, x[31:1]}; co = x[0]; eff = 1;
        end else if (n == 0) begin
            res = x; co = ci; eff = 0;
        end else begin
            case (o)
                2'b00: begin
                    eff = (n > 33) ? 33 : n;
                    if (n < 32)       begin res = x << n; co = x[32-n]; end
                    else if (n == 32) begin res = 0;      co = x[0];    end
                    else              begin res = 0;      co = 1'b0;    end
                end
                2'b01: begin
                    eff = (n > 33) ? 33 : n;
                    if (n < 32)       begin res = x >> n; co = x[n-1]; end
                    else if (n == 32) begin res = 0;      co = x[31];  end
                    else              begin res = 0;      co = 1'b0;   end
                end
                2'b10: begin
                    eff = (n > 32) ? 32 : n;
                    if (n < 32) begin res = $signed(x) >>> n; co = x[n-1]; end
                    else        begin res = {32{x[31]}};     co = x[31];  end
                end
                default: begin
                    m = n % 32;
                    if (m == 0) begin
                        res = x; co = x[31]; eff = 32;
                    end else begin
                        dbl = {x, x} >> m;
                        res = dbl[31:0]; co = x[m-1]; eff = m;
                    end
                end
            endcase
        end
    endfunction

    // driver: issue one operation, follow both instances to done and one beyond
    task automatic run_op(input logic [1:0] o, input logic r, input logic [7:0] a,
                          input logic [31:0] x, input logic ci, input logic noise);
        logic [31:0] er;
        logic        ec;
        int          eff, lat4, lat1, n;
        logic        got4, got1;
        model(o, r, a, x, ci, er, ec, eff);
        lat4 = (eff + 3) / 4 + 1;
        lat1 = eff + 1;
        op = o; rrx = r; amount = a; operand = x; carry_in = ci; start = 1'b1;
        tick();
        start = 1'b0;
        got4 = 1'b0; got1 = 1'b0; n = 1;
        while (!(got4 && got1) && n <= 40) begin
            if (done4) begin
                if (got4) check("done4_pulse", 32'(done4), 32'd0);
                else begin
                    got4 = 1'b1;
                    check("lat4", n, lat4);
                    check("res4", res4, er);
                    check("carry4", 32'(co4), 32'(ec));
                end
            end else if (!got4) check("busy4", 32'(busy4), 32'd1);
            if (done1) begin
                if (got1) check("done1_pulse", 32'(done1), 32'd0);
                else begin
                    got1 = 1'b1;
                    check("lat1", n, lat1);
                    check("res1", res1, er);
                    check("carry1", 32'(co1), 32'(ec));
                end
            end else if (!got1) check("busy1", 32'(busy1), 32'd1);
            if (noise && n < lat4) begin
                start    = 1'($urandom_range(0, 1));
                op       = 2'($urandom_range(0, 3));
                rrx      = 1'($urandom_range(0, 1));
                amount   = 8'($urandom_range(0, 255));
                operand  = $urandom;
                carry_in = 1'($urandom_range(0, 1));
            end else start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        check("timeout", {30'd0, got4, got1}, 32'd3);
        check("idle4", {done4, busy4, 30'(st4)}, {2'b00, 30'(IDLE)});
        check("idle1", {done1, busy1, 30'(st1)}, {2'b00, 30'(IDLE)});
        check("hold4", res4, er);
        check("hold1", res1, er);
        check("holdc", {30'd0, co4, co1}, {30'd0, ec, ec});
    endtask

    initial begin
        int sel;
        logic [7:0] a;
        reset = 1'b1; start = 1'b0; op = 2'b00; rrx = 1'b0;
        amount = '0; operand = '0; carry_in = 1'b0;
        tick(); tick();
        check("rst_res4", res4, 32'd0);
        check("rst_res1", res1, 32'd0);
        check("rst_flags", {co4, busy4, done4, co1, busy1, done1}, 6'd0);
        check("rst_state", {30'(st4), 2'(st1)}, {30'(IDLE), 2'(IDLE)});
        reset = 1'b0;
        tick();

        // directed scenarios
        run_op(2'b00, 1'b0, 8'd4,   32'h8000_000F, 1'b0, 1'b0);
        run_op(2'b01, 1'b0, 8'd32,  32'h8000_0001, 1'b0, 1'b0);
        run_op(2'b01, 1'b0, 8'd40,  32'h8000_0001, 1'b1, 1'b0);
        run_op(2'b10, 1'b0, 8'd200, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b11, 1'b0, 8'd36,  32'h0000_0013, 1'b1, 1'b0);
        run_op(2'b11, 1'b0, 8'd32,  32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b11, 1'b1, 8'd77,  32'h0000_0003, 1'b1, 1'b0);
        run_op(2'b00, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 1'b0);
        run_op(2'b00, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(2'b00, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 1'b0);
        run_op(2'b00, 1'b0, 8'd4,   32'h8000_000F, 1'b0, 1'b1);

        // reset mid-RUN aborts with no done
        op = 2'b00; rrx = 1'b0; amount = 8'd33; operand = 32'hDEAD_BEEF; carry_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("abort_res", res4 | res1, 32'd0);
        check("abort_flags", {co4, busy4, done4, co1, busy1, done1}, 6'd0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check("abort_nodone", {30'd0, done4, done1}, 32'd0);
            tick();
        end

        // randomized operations with input noise while busy
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       a = 8'd0;
                1:       a = 8'd32;
                2:       a = 8'd33;
                3:       a = 8'($urandom_range(1, 31));
                4:       a = 8'($urandom_range(34, 255));
                default: a = {3'($urandom_range(0, 7)), 5'd0};
            endcase
            run_op(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), a,
                   $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
